// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture: pairs OV7670 bytes into RGB565 words with column/row/address tracking.
// Optional CAM_DECIMATE_EN: 2x2 decimation (emit only even x/y, ADDR counts kept pixels).
`default_nettype none

module ov7670_pixel_capture #(
  parameter int RESOLUTION_W = 640,
  parameter int RESOLUTION_H = 480
) (
  input  logic        PCLK,
  input  logic        RESET_N,
  input  logic [7:0]  PIXEL,
  input  logic        VSYNC,
  input  logic        HREF,
  output logic [15:0] PIXEL_OUT,
  output logic        PIXEL_VALID,
  output logic [9:0]  PIXEL_X,
  output logic [8:0]  PIXEL_Y,
  output logic [18:0] ADDR,
  output logic        FRAME_START,
  output logic        FRAME_DONE,
  output logic        FRAME_ERR
);

  localparam logic [1:0] S_SYNC   = 2'd0;
  localparam logic [1:0] S_VBLANK = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  localparam logic [10:0] C_W = 11'(RESOLUTION_W);
  localparam logic [9:0]  C_H = 10'(RESOLUTION_H);

  logic [1:0]  r_state;
  logic        r_phase;
  logic [7:0]  r_hi;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic [18:0] r_addr;
  logic        r_err;
  logic        r_href_d;

  logic        w_active;
  logic        w_in_range;
  logic        w_keep;
  logic        w_line_end;
  logic        w_line_err;
  logic [10:0] w_x_inc;
  logic [9:0]  w_y_next;
  logic [9:0]  w_y_eff;
  logic        w_frame_err;

  assign w_active   = (r_state == S_ACTIVE);
  assign w_in_range = (r_x < C_W) && (r_y < C_H);
`ifdef CAM_DECIMATE_EN
  assign w_keep     = ~r_x[0] & ~r_y[0];
`else
  assign w_keep     = 1'b1;
`endif
  assign w_line_end = w_active && !HREF && r_href_d;
  assign w_line_err = w_line_end && ((r_x != C_W) || r_phase);
  assign w_x_inc    = (r_x == 11'h7FF) ? r_x : r_x + 11'd1;
  assign w_y_next   = (r_y == 10'd511) ? r_y : r_y + 10'd1;
  // A line ending in the same cycle as VSYNC rises still counts toward y.
  assign w_y_eff    = w_line_end ? w_y_next : r_y;
  assign w_frame_err = (w_y_eff != C_H) || HREF;

  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_SYNC;
      r_phase     <= 1'b0;
      r_hi        <= 8'd0;
      r_x         <= 11'd0;
      r_y         <= 10'd0;
      r_addr      <= 19'd0;
      r_err       <= 1'b0;
      r_href_d    <= 1'b0;
      PIXEL_OUT   <= 16'd0;
      PIXEL_VALID <= 1'b0;
      PIXEL_X     <= 10'd0;
      PIXEL_Y     <= 9'd0;
      ADDR        <= 19'd0;
      FRAME_START <= 1'b0;
      FRAME_DONE  <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      PIXEL_VALID <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_DONE  <= 1'b0;
      r_href_d    <= w_active ? HREF : 1'b0;
      case (r_state)
        S_SYNC: begin
          if (VSYNC) r_state <= S_VBLANK;
        end
        S_VBLANK: begin
          if (!VSYNC) begin
            r_state     <= S_ACTIVE;
            FRAME_START <= 1'b1;
            FRAME_ERR   <= 1'b0;
            r_x         <= 11'd0;
            r_y         <= 10'd0;
            r_addr      <= 19'd0;
            r_phase     <= 1'b0;
            r_err       <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (VSYNC) begin
            // Bytes in the VSYNC-rise cycle are discarded with the aborted line.
            r_state    <= S_VBLANK;
            FRAME_DONE <= 1'b1;
            FRAME_ERR  <= r_err | w_line_err | w_frame_err;
            r_err      <= r_err | w_line_err | w_frame_err;
            r_phase    <= 1'b0;
          end else if (HREF) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
              r_hi <= PIXEL;
            end else begin
              r_x <= w_x_inc;
              if (w_in_range) begin
                if (w_keep) begin
                  PIXEL_VALID <= 1'b1;
                  PIXEL_OUT   <= {r_hi, PIXEL};
                  PIXEL_X     <= r_x[9:0];
                  PIXEL_Y     <= r_y[8:0];
                  ADDR        <= r_addr;
                  r_addr      <= r_addr + 19'd1;
                end
              end else begin
                r_err <= 1'b1;
              end
            end
          end else if (r_href_d) begin
            if (w_line_err) r_err <= 1'b1;
            r_x     <= 11'd0;
            r_phase <= 1'b0;
            r_y     <= w_y_next;
          end
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ov7670_pixel_capture.sv
// Scoreboard bench for ov7670_pixel_capture: driver pushes expected pixels/frame status, monitor pops and compares.
`default_nettype none

module tb_ov7670_pixel_capture;

`ifdef CAM_DECIMATE_EN
  localparam int W = 4;
  localparam int H = 4;
  localparam bit DEC = 1'b1;
`else
  localparam int W = 4;
  localparam int H = 2;
  localparam bit DEC = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        RESET_N;
  logic [7:0]  PIXEL;
  logic        VSYNC;
  logic        HREF;
  logic [15:0] PIXEL_OUT;
  logic        PIXEL_VALID;
  logic [9:0]  PIXEL_X;
  logic [8:0]  PIXEL_Y;
  logic [18:0] ADDR;
  logic        FRAME_START;
  logic        FRAME_DONE;
  logic        FRAME_ERR;

  ov7670_pixel_capture #(.RESOLUTION_W(W), .RESOLUTION_H(H)) dut (
    .PCLK(PCLK), .RESET_N(RESET_N), .PIXEL(PIXEL), .VSYNC(VSYNC), .HREF(HREF),
    .PIXEL_OUT(PIXEL_OUT), .PIXEL_VALID(PIXEL_VALID), .PIXEL_X(PIXEL_X),
    .PIXEL_Y(PIXEL_Y), .ADDR(ADDR), .FRAME_START(FRAME_START),
    .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [15:0] w;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [18:0] a;
  } pix_t;

  pix_t exp_q[$];
  bit   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_pix = 0, n_start = 0, n_done = 0;
  pix_t got_pix, exp_pix, first_pix, last_pix;
  bit   exp_err;
  logic prev_valid = 1'b0;

  // Monitor
  always @(negedge PCLK) begin
    if (RESET_N) begin
      if (PIXEL_VALID) begin
        got_pix = {PIXEL_OUT, PIXEL_X, PIXEL_Y, ADDR};
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL valid_back_to_back got two consecutive strobes, required gap");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel got w=%h x=%0d y=%0d a=%0d, required no strobe",
                   PIXEL_OUT, PIXEL_X, PIXEL_Y, ADDR);
        end else begin
          exp_pix = exp_q.pop_front();
          if (got_pix !== exp_pix) begin
            errors++;
            $display("FAIL pixel got w=%h x=%0d y=%0d a=%0d required w=%h x=%0d y=%0d a=%0d",
                     got_pix.w, got_pix.x, got_pix.y, got_pix.a,
                     exp_pix.w, exp_pix.x, exp_pix.y, exp_pix.a);
          end
        end
        if (n_pix == 0) first_pix = got_pix;
        last_pix = got_pix;
        n_pix++;
      end
      prev_valid = PIXEL_VALID;
      if (FRAME_DONE) begin
        checks++;
        n_done++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_done got FRAME_DONE, required none");
        end else begin
          exp_err = done_q.pop_front();
          if (FRAME_ERR !== exp_err) begin
            errors++;
            $display("FAIL frame_err got %0b required %0b", FRAME_ERR, exp_err);
          end
        end
      end
      if (FRAME_START) n_start++;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  // Reference model of the camera-side frame, used only while driving.
  int         m_x, m_y, m_addr;
  bit         m_err, m_ph;
  logic [7:0] m_hi, bval;

  task automatic drive(input logic v, input logic h, input logic [7:0] p);
    @(negedge PCLK);
    VSYNC = v;
    HREF  = h;
    PIXEL = p;
  endtask

  task automatic start_frame();
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    m_x = 0; m_y = 0; m_addr = 0; m_err = 1'b0; m_ph = 1'b0; bval = 8'h01;
  endtask

  task automatic send_bytes(input int nb);
    for (int i = 0; i < nb; i++) begin
      drive(1'b0, 1'b1, bval);
      if (!m_ph) begin
        m_hi = bval;
      end else begin
        if (m_x < W && m_y < H) begin
          if (!DEC || (m_x % 2 == 0 && m_y % 2 == 0)) begin
            exp_q.push_back({m_hi, bval, 10'(m_x), 9'(m_y), 19'(m_addr)});
            m_addr++;
          end
        end else begin
          m_err = 1'b1;
        end
        m_x++;
      end
      m_ph = ~m_ph;
      bval = bval + 8'd1;
    end
  endtask

  task automatic send_line(input int nb);
    send_bytes(nb);
    drive(1'b0, 1'b0, 8'h00);
    if (m_x != W || m_ph) m_err = 1'b1;
    m_x = 0; m_ph = 1'b0; m_y++;
    repeat (2) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_frame();
    drive(1'b1, 1'b0, 8'h00);
    if (m_y != H) m_err = 1'b1;
    done_q.push_back(m_err);
    repeat (3) drive(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; VSYNC = 1'b0; HREF = 1'b0; PIXEL = 8'h00;
    repeat (3) @(negedge PCLK);
    #2;
    check("reset_valid", {63'd0, PIXEL_VALID}, 64'd0);
    check("reset_data", {10'd0, PIXEL_OUT, PIXEL_X, PIXEL_Y, ADDR}, 64'd0);
    check("reset_pulses", {62'd0, FRAME_START, FRAME_DONE}, 64'd0);
    check("reset_err", {63'd0, FRAME_ERR}, 64'd0);

    // Reset released mid-frame: nothing until VSYNC high-then-low.
    RESET_N = 1'b1;
    for (int i = 0; i < 12; i++) drive(1'b0, (i % 6) < 4, 8'hA0 + 8'(i));
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    #2;
    check("sync_no_start", 64'(n_start), 64'd0);
    check("sync_no_pixels", 64'(n_pix), 64'd0);

    // Frame 1: clean frame.
    start_frame();
    for (int l = 0; l < H; l++) send_line(2 * W);
    end_frame();
    #2;
    check("start_once", 64'(n_start), 64'd1);
    check("f1_err", {63'd0, FRAME_ERR}, 64'd0);
    check("f1_first", 64'(first_pix), 64'({16'h0102, 10'd0, 9'd0, 19'd0}));
`ifdef CAM_DECIMATE_EN
    check("f1_count", 64'(n_pix), 64'd4);
    check("f1_last", 64'(last_pix), 64'({16'h1516, 10'd2, 9'd2, 19'd3}));
`else
    check("f1_count", 64'(n_pix), 64'd8);
    check("f1_last", 64'(last_pix), 64'({16'h0F10, 10'd3, 9'd1, 19'd7}));
`endif

    // Frame 2: odd 7-byte line.
    start_frame();
    send_line(7);
    for (int l = 1; l < H; l++) send_line(2 * W);
    end_frame();
    #2;
    check("odd_line_err", {63'd0, FRAME_ERR}, 64'd1);

    // Frame 3: clean frame clears the error.
    start_frame();
    for (int l = 0; l < H; l++) send_line(2 * W);
    end_frame();
    #2;
    check("clean_err", {63'd0, FRAME_ERR}, 64'd0);

    // Frame 4: one line too many.
    start_frame();
    for (int l = 0; l < H + 1; l++) send_line(2 * W);
    end_frame();
    #2;
    check("extra_line_err", {63'd0, FRAME_ERR}, 64'd1);
`ifndef CAM_DECIMATE_EN
    check("extra_line_addr", 64'(last_pix.a), 64'd7);
`endif

    // Frame 5: VSYNC rises while HREF is high mid-line.
    start_frame();
    send_line(2 * W);
    send_bytes(4);
    drive(1'b1, 1'b1, bval);
    m_err = 1'b1;
    done_q.push_back(m_err);
    @(negedge PCLK);
    #2;
    check("abort_done_next_cycle", {63'd0, FRAME_DONE}, 64'd1);
    check("abort_err", {63'd0, FRAME_ERR}, 64'd1);
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    #2;
    check("start_count", 64'(n_start), 64'd5);
    check("done_count", 64'(n_done), 64'd5);
    check("pix_queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_queue_empty", 64'(done_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
